// File: rtl/riscv_load_pkg.sv
// Shared constants for the load data path: funct3 load types, address regions,
// read-source select and the load FSM state encoding.
package riscv_load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] REGION_DMEM     = 4'b0001;
    localparam logic [3:0] REGION_DMEM_ALT = 4'b0011;
    localparam logic [3:0] REGION_BIOS     = 4'b0100;
    localparam logic [3:0] REGION_MMIO     = 4'b1000;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DMEM = 2'd1,
        SRC_BIOS = 2'd2,
        SRC_MMIO = 2'd3
    } load_src_t;

    // state     | meaning
    // IDLE      | no load result pending
    // LOAD      | result extracted from live DMEM/BIOS read data
    // MMIO_WAIT | MMIO read outstanding, core stalled
    // HOLD      | result replayed from the hold register
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_MMIO_WAIT = 2'd2,
        S_HOLD      = 2'd3
    } load_state_t;

endpackage

// File: rtl/load_extract.sv
// Byte/half/word extraction with sign or zero extension of a 32-bit read word.
// LOAD_MISALIGN_CHECK_EN enables misaligned LH/LHU/LW detection (result forced to 0).
module load_extract
    import riscv_load_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    input  logic        i_passthru,
    output logic [31:0] o_result,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_mis;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = i_word;
        case (i_funct3)
            F3_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  w_ext = {24'b0, w_byte};
            F3_LH:   w_ext = {{16{w_half[15]}}, w_half};
            F3_LHU:  w_ext = {16'b0, w_half};
            default: w_ext = i_word;
        endcase
    end

`ifdef LOAD_MISALIGN_CHECK_EN
    logic w_is_half;
    logic w_is_word;

    assign w_is_half = (i_funct3 == F3_LH) || (i_funct3 == F3_LHU);
    assign w_is_word = !w_is_half && (i_funct3 != F3_LB) && (i_funct3 != F3_LBU);
    assign w_mis     = !i_passthru &&
                       ((w_is_half && i_off[0]) || (w_is_word && (i_off != 2'b00)));
`else
    assign w_mis = 1'b0;
`endif

    // MMIO words bypass extraction entirely
    assign o_result   = i_passthru ? i_word : (w_mis ? 32'b0 : w_ext);
    assign o_misalign = w_mis;

endmodule

// File: rtl/load_data_unit.sv
// Load data path: captures load info in EX, selects/extracts the read word in WB,
// holds it across stalls and stalls the core on MMIO reads. Option: LOAD_MISALIGN_CHECK_EN.
module load_data_unit
    import riscv_load_pkg::*;
#(
    parameter int         AWIDTH      = 32,
    parameter int         DWIDTH      = 32,
    parameter logic [3:0] DMEM_REGION = REGION_DMEM,
    parameter logic [3:0] BIOS_REGION = REGION_BIOS,
    parameter logic [3:0] MMIO_REGION = REGION_MMIO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_load_valid,
    input  logic [AWIDTH-1:0] ex_addr,
    input  logic [2:0]        ex_funct3,
    input  logic              stall,
    input  logic [DWIDTH-1:0] dmem_dout,
    input  logic [DWIDTH-1:0] bios_dout,
    output logic              mmio_re,
    input  logic [DWIDTH-1:0] mmio_rdata,
    input  logic              mmio_rvalid,
    output logic [DWIDTH-1:0] wb_load_data,
    output logic              wb_load_valid,
    output logic              load_stall_req,
    output logic              load_misalign
);

    load_state_t r_state;
    load_state_t w_state_nxt;
    load_state_t w_follow;
    load_src_t   r_src;
    load_src_t   w_src;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_hold;
    logic        r_hold_mis;
    logic [3:0]  w_region;
    logic        w_accept;
    logic        w_hold_en;
    logic [31:0] w_word;
    logic [31:0] w_ext;
    logic        w_ext_mis;
    logic        w_unused_addr;

    assign w_region      = ex_addr[AWIDTH-1 -: 4];
    assign w_unused_addr = ^ex_addr[AWIDTH-5:2];

    always_comb begin
        w_src = SRC_NONE;
        if ((w_region == DMEM_REGION) || (w_region == REGION_DMEM_ALT)) begin
            w_src = SRC_DMEM;
        end else if (w_region == BIOS_REGION) begin
            w_src = SRC_BIOS;
        end else if (w_region == MMIO_REGION) begin
            w_src = SRC_MMIO;
        end
    end

    assign w_accept = rst_n && ex_load_valid && !stall && (r_state != S_MMIO_WAIT);
    assign mmio_re  = w_accept && (w_src == SRC_MMIO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src    <= SRC_NONE;
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
        end else if (w_accept) begin
            r_src    <= w_src;
            r_funct3 <= ex_funct3;
            r_off    <= ex_addr[1:0];
        end
    end

    always_comb begin
        w_word = 32'b0;
        case (r_src)
            SRC_DMEM: w_word = dmem_dout;
            SRC_BIOS: w_word = bios_dout;
            SRC_MMIO: w_word = mmio_rdata;
            default:  w_word = 32'b0;
        endcase
    end

    load_extract u_extract (
        .i_word     (w_word),
        .i_off      (r_off),
        .i_funct3   (r_funct3),
        .i_passthru (r_src == SRC_MMIO),
        .o_result   (w_ext),
        .o_misalign (w_ext_mis)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold     <= 32'b0;
            r_hold_mis <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hold_en) begin
                r_hold     <= w_ext;
                r_hold_mis <= w_ext_mis;
            end
        end
    end

    // Successor shared by IDLE, LOAD and HOLD once the pipeline moves
    assign w_follow = !w_accept            ? S_IDLE :
                      (w_src == SRC_MMIO)  ? S_MMIO_WAIT : S_LOAD;

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_en      = 1'b0;
        wb_load_valid  = 1'b0;
        wb_load_data   = 32'b0;
        load_misalign  = 1'b0;
        load_stall_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = w_follow;
            end
            S_LOAD: begin
                wb_load_valid = 1'b1;
                wb_load_data  = w_ext;
                load_misalign = w_ext_mis;
                if (stall) begin
                    w_hold_en   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = w_follow;
                end
            end
            S_MMIO_WAIT: begin
                load_stall_req = 1'b1;
                if (mmio_rvalid) begin
                    w_hold_en   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                wb_load_valid = 1'b1;
                wb_load_data  = r_hold;
                load_misalign = r_hold_mis;
                if (!stall) begin
                    w_state_nxt = w_follow;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_data_unit.sv
// Scoreboard bench for load_data_unit: driver pushes expected results from a
// reference model, a negedge monitor compares whenever a result is presented.
module tb_load_data_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_load_valid;
    logic [31:0] ex_addr;
    logic [2:0]  ex_funct3;
    logic        tb_stall;
    logic        stall;
    logic [31:0] dmem_dout;
    logic [31:0] bios_dout;
    logic        mmio_re;
    logic [31:0] mmio_rdata;
    logic        mmio_rvalid;
    logic [31:0] wb_load_data;
    logic        wb_load_valid;
    logic        load_stall_req;
    logic        load_misalign;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // The core's global stall includes the unit's own stall request
    assign stall = tb_stall | load_stall_req;

    load_data_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_load_valid  (ex_load_valid),
        .ex_addr        (ex_addr),
        .ex_funct3      (ex_funct3),
        .stall          (stall),
        .dmem_dout      (dmem_dout),
        .bios_dout      (bios_dout),
        .mmio_re        (mmio_re),
        .mmio_rdata     (mmio_rdata),
        .mmio_rvalid    (mmio_rvalid),
        .wb_load_data   (wb_load_data),
        .wb_load_valid  (wb_load_valid),
        .load_stall_req (load_stall_req),
        .load_misalign  (load_misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_dmem(input logic [3:0] rg);
        return (rg == 4'h1) || (rg == 4'h3);
    endfunction

    function automatic exp_t model(input logic [31:0] addr, input logic [2:0] f3,
                                   input logic [31:0] word_in);
        exp_t        e;
        logic [3:0]  rg;
        logic [31:0] word;
        logic [31:0] b;
        logic [31:0] h;
        int          off;
        bit          is_half;
        bit          is_byte;
        rg    = addr[31:28];
        off   = int'(addr[1:0]);
        word  = word_in;
        e.mis = 1'b0;
        if (rg == 4'h8) begin
            e.data = word;
            return e;
        end
        if (!(is_dmem(rg) || rg == 4'h4)) word = 32'h0;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    e.data = (b >= 128)   ? b - 32'd256   : b;
            3'd4:    e.data = b;
            3'd1:    e.data = (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    e.data = h;
            default: e.data = word;
        endcase
        is_half = (f3 == 3'd1) || (f3 == 3'd5);
        is_byte = (f3 == 3'd0) || (f3 == 3'd4);
`ifdef LOAD_MISALIGN_CHECK_EN
        if ((is_half && (off % 2 == 1)) || (!is_half && !is_byte && off != 0)) begin
            e.mis  = 1'b1;
            e.data = 32'h0;
        end
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && wb_load_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_valid: got valid=1 data=%h, expected no result at %0t",
                         wb_load_data, $time);
            end else begin
                chk("wb_load_data", wb_load_data, q[0].data);
                chk("load_misalign", {31'b0, load_misalign}, {31'b0, q[0].mis});
                if (!stall) void'(q.pop_front());
            end
        end
    end

    // Issue one load from an accepting state; returns inside its first valid cycle
    // (or the first non-stalled one when hold > 0)
    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] word, input int hold, input int lat);
        logic [3:0] rg;
        int         cnt;
        rg            = addr[31:28];
        ex_load_valid = 1'b1;
        ex_addr       = addr;
        ex_funct3     = f3;
        tb_stall      = 1'b0;
        q.push_back(model(addr, f3, word));
        #1;
        chk("mmio_re_on_accept", {31'b0, mmio_re}, {31'b0, rg == 4'h8});
        @(posedge clk); #1;
        if (rg == 4'h8) begin
            cnt           = 0;
            ex_load_valid = 1'b1;
            ex_addr       = {4'h8, 28'($urandom)};
            ex_funct3     = 3'd2;
            #1;
            for (int i = 0; i < lat; i++) begin
                if (load_stall_req) cnt++;
                chk("mmio_re_blocked", {31'b0, mmio_re}, 32'd0);
                tb_stall = 1'($urandom_range(0, 1));
                if (i == lat - 1) begin
                    mmio_rvalid = 1'b1;
                    mmio_rdata  = word;
                end
                @(posedge clk); #1;
            end
            mmio_rvalid   = 1'b0;
            mmio_rdata    = $urandom;
            ex_load_valid = 1'b0;
            #1;
            chk("stall_req_cycles", cnt, lat);
            chk("mmio_result_latency", {31'b0, wb_load_valid}, 32'd1);
        end else begin
            ex_load_valid = 1'b0;
            ex_addr       = $urandom;
            ex_funct3     = 3'($urandom);
            dmem_dout     = is_dmem(rg)  ? word : $urandom;
            bios_dout     = (rg == 4'h4) ? word : $urandom;
            #1;
            chk("load_latency", {31'b0, wb_load_valid}, 32'd1);
        end
        tb_stall = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            dmem_dout = $urandom;
            bios_dout = $urandom;
            if (i == hold - 1) tb_stall = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        ex_load_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tb_stall    = 1'($urandom_range(0, 1));
            mmio_rvalid = ($urandom_range(0, 2) == 0);
            mmio_rdata  = $urandom;
            @(posedge clk); #1;
        end
        tb_stall    = 1'b0;
        mmio_rvalid = 1'b0;
    endtask

    initial begin
        logic [3:0]  regions[7];
        logic [3:0]  rg;
        logic [2:0]  f3;
        logic [31:0] addr;
        regions = '{4'h1, 4'h3, 4'h4, 4'h8, 4'h0, 4'h2, 4'hF};

        rst_n         = 1'b0;
        ex_load_valid = 1'b0;
        ex_addr       = 32'h0;
        ex_funct3     = 3'd0;
        tb_stall      = 1'b0;
        dmem_dout     = 32'h0;
        bios_dout     = 32'h0;
        mmio_rdata    = 32'h0;
        mmio_rvalid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, wb_load_valid}, 32'd0);
        chk("reset_data", wb_load_data, 32'd0);
        chk("reset_stall_req", {31'b0, load_stall_req}, 32'd0);
        chk("reset_mmio_re", {31'b0, mmio_re}, 32'd0);
        chk("reset_misalign", {31'b0, load_misalign}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_load(32'h1000_0003, 3'd0, 32'h80FF_FF7F, 0, 0);
        chk("lb_sign_byte3", wb_load_data, 32'hFFFF_FF80);
        idle(1);
        do_load(32'h1000_0002, 3'd5, 32'hBEEF_1234, 0, 0);
        chk("lhu_upper", wb_load_data, 32'h0000_BEEF);
        do_load(32'h1000_0002, 3'd1, 32'hBEEF_1234, 0, 0);
        chk("lh_upper", wb_load_data, 32'hFFFF_BEEF);
        idle(2);
        do_load(32'h4000_0010, 3'd2, 32'hCAFE_F00D, 3, 0);
        chk("bios_lw_held", wb_load_data, 32'hCAFE_F00D);
        idle(2);
        do_load(32'h8000_0004, 3'd2, 32'h0000_0041, 0, 5);
        chk("mmio_lw", wb_load_data, 32'h0000_0041);
        idle(1);
        do_load(32'h1000_0001, 3'd0, 32'h1122_8344, 0, 0);
        chk("b2b_lb", wb_load_data, 32'hFFFF_FF83);
        do_load(32'h3000_0002, 3'd1, 32'h7ABC_0000, 0, 0);
        chk("b2b_lh", wb_load_data, 32'h0000_7ABC);
        do_load(32'h5000_0000, 3'd2, 32'h1234_5678, 0, 0);
        chk("unmapped_zero", wb_load_data, 32'h0);

        // Reset while an MMIO read is outstanding, then a stray rvalid
        @(posedge clk); #1;
        ex_load_valid = 1'b1;
        ex_addr       = 32'h8000_0000;
        ex_funct3     = 3'd2;
        @(posedge clk); #1;
        ex_load_valid = 1'b0;
        #1;
        chk("mmio_wait_stall_req", {31'b0, load_stall_req}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        mmio_rvalid = 1'b1;
        mmio_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mmio_rvalid = 1'b0;
        chk("abort_stall_req", {31'b0, load_stall_req}, 32'd0);
        chk("abort_valid", {31'b0, wb_load_valid}, 32'd0);
        @(posedge clk); #1;
        chk("abort_valid_later", {31'b0, wb_load_valid}, 32'd0);

        do_load(32'h1000_0001, 3'd2, 32'h1234_5678, 0, 0);
`ifdef LOAD_MISALIGN_CHECK_EN
        chk("misalign_lw_data", wb_load_data, 32'h0);
        chk("misalign_lw_flag", {31'b0, load_misalign}, 32'd1);
`else
        chk("misalign_lw_data", wb_load_data, 32'h1234_5678);
        chk("misalign_lw_flag", {31'b0, load_misalign}, 32'd0);
`endif
        idle(1);

        for (int n = 0; n < 300; n++) begin
            rg   = regions[$urandom_range(0, 6)];
            addr = {rg, 28'($urandom)};
            f3   = (rg == 4'h8) ? 3'd2 : 3'($urandom);
            do_load(addr, f3, $urandom,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                    $urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
